seq_bit_serializer: RTL and testbench
=====================================

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_word, input, WIDTH, parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1, in_word is valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-008 SHALL have port ser_en, input, 1, downstream advance enable; when low, the output bit is held.
REQ-009 SHALL have port ser_bit, output, 1, serial bit, which drives the 1011 detector's inp_bit.
REQ-010 SHALL have port ser_valid, output, 1, ser_bit carries a word bit.
REQ-011 SHALL have port word_done, output, 1, the last bit of a word is consumed this cycle.
REQ-012 SHALL have port busy, output, 1, shifter or buffer holds data.

Function
REQ-013 SHALL transfer a word on a posedge where in_valid=1 and in_ready=1; no transfer otherwise.
REQ-014 SHALL drive in_ready = !reset && !buf_full, where buf_full flags a one-entry skid buffer.
REQ-015 SHALL implement FSM states IDLE (shifter empty) and SHIFT (shifter loaded).
REQ-016 IDLE + transfer: SHALL load in_word into the shifter, clear the bit counter, and go to SHIFT; ser_valid=1 on the next cycle, showing the first bit.
REQ-017 SHIFT: ser_bit SHALL equal the current bit, and ser_valid SHALL be 1.
REQ-018 SHIFT + ser_en=1: SHALL advance one bit per cycle.
REQ-019 SHIFT + ser_en=0: SHALL hold ser_bit, the counter and the shifter unchanged.
REQ-020 word_done SHALL be 1, combinationally, only when in SHIFT with counter=WIDTH-1 and ser_en=1.
REQ-021 On word_done with buf_full=1: SHALL load the buffer into the shifter, clear buf_full, and stay in SHIFT, with no idle cycle between words.
REQ-022 On word_done with buf_full=0 and a transfer in the same cycle: SHALL load in_word directly into the shifter and stay in SHIFT.
REQ-023 On word_done with no buffered word and no transfer: SHALL go to IDLE; ser_valid=0 on the next cycle.
REQ-024 A transfer in SHIFT when word_done=0 SHALL write the buffer and set buf_full.
REQ-025 Back-to-back words with ser_en held at 1 SHALL produce a continuous bit stream at 1 bit/clk.
REQ-026 In IDLE, ser_bit SHALL be 0 and ser_valid SHALL be 0.
REQ-027 busy SHALL equal (state==SHIFT) || buf_full.
REQ-028 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for clk, force state=IDLE, buf_full=0, counter=0, ser_bit=0, ser_valid=0, word_done=0, busy=0, in_ready=0.
REQ-030 A reset asserted mid-word SHALL discard the shifter and buffer contents; no partial word resumes after reset.
REQ-031 First posedge after reset deassertion: in_ready SHALL be 1 and a transfer SHALL be accepted.

Verification
REQ-032 Reset, then WIDTH=8, MSB_FIRST=1, send 8'hB0 with ser_en=1 -> ser_bit sequence 1,0,1,1,0,0,0,0 on 8 consecutive cycles, word_done on cycle 8, ser_valid=0 on cycle 9.
REQ-033 Send 8'hB5 then 8'h0B back-to-back with ser_en=1 -> 16 contiguous bits 10110101 00001011; in_ready=0 while the buffer is full; two word_done pulses 8 cycles apart.
REQ-034 Send 8'hB5 and drop ser_en low for 3 cycles after bit 2 -> ser_bit held at 1 for 3 cycles, total word duration 11 cycles, bit order unchanged.
REQ-035 Set MSB_FIRST=0 and send 8'h0D -> ser_bit sequence 1,0,1,1,0,0,0,0.
REQ-036 Assert reset asynchronously mid-clock after bit 4 of 8'hFF, with the buffer full -> outputs go to 0 before the next edge; after release, a new word 8'hB0 serializes correctly with no stale bits.
REQ-037 Connect to the 1011 detector and feed 8'hB0 -> detector seq_seen asserts once, 4 cycles after the first bit is presented.

Source files
------------

// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-stream signals of seq_bit_serializer.
// master drives words and the advance enable; slave is the serializer.
interface seq_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_word;
    logic             in_valid;
    logic             in_ready;
    logic             ser_en;
    logic             ser_bit;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_word, in_valid, ser_en,
        input  in_ready, ser_bit, ser_valid, word_done, busy
    );

    modport slave (
        input  in_word, in_valid, ser_en,
        output in_ready, ser_bit, ser_valid, word_done, busy
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter with a one-entry skid buffer, so that back-to-back
// words stream out at one bit per clock with no gap between them.
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                reset,
    seq_bit_serializer_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             xfer;
    logic             done;
    logic [WIDTH-1:0] shift_adv;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave SHIFT only when the last bit goes out with nothing queued behind it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (xfer) state_d = StShift;
            StShift: if (done && !buf_full_q && !xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.ser_valid = (state_q == StShift);
        bus.ser_bit   = 1'b0;
        if (state_q == StShift) begin
            bus.ser_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        end
        done          = (state_q == StShift) && (cnt_q == LastCnt) && bus.ser_en;
        bus.word_done = done;
        bus.busy      = (state_q == StShift) || buf_full_q;
        bus.in_ready  = !reset && !buf_full_q;
    end

    always_comb begin
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;
        if (state_q == StIdle) begin
            if (xfer) begin
                shift_d = bus.in_word;
                cnt_d   = '0;
            end
        end else if (done) begin
            // in_ready is low while the buffer is full, so the two reload sources are exclusive
            cnt_d = '0;
            if (buf_full_q) begin
                shift_d    = buf_q;
                buf_full_d = 1'b0;
            end else if (xfer) begin
                shift_d = bus.in_word;
            end
        end else begin
            if (bus.ser_en) begin
                shift_d = shift_adv;
                cnt_d   = cnt_q + CntW'(1);
            end
            if (xfer) begin
                buf_d      = bus.in_word;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first and an LSB-first instance see the same stimulus
// and are compared each cycle against a queue-of-bits model of the expected stream.
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] word = 8'h00;
    logic       valid = 1'b0;
    logic       en = 1'b0;

    int n_vec = 0;
    int n_fail = 0;

    // Reference model: bits still owed, in emission order, plus a last-bit-of-word flag.
    logic qm[$];
    logic ql[$];
    logic lastq[$];
    int   held = 0;

    // Observed stream bookkeeping
    logic [15:0] obs_m = '0;
    logic [7:0]  obs_l = '0;
    logic [3:0]  hist = '0;
    int          nbits = 0;
    int          det_hits = 0;
    int          det_at = 0;

    always #5 clk = ~clk;

    seq_bit_serializer_if #(.WIDTH(8)) if_m ();
    seq_bit_serializer_if #(.WIDTH(8)) if_l ();

    assign if_m.in_word  = word;
    assign if_m.in_valid = valid;
    assign if_m.ser_en   = en;
    assign if_l.in_word  = word;
    assign if_l.in_valid = valid;
    assign if_l.ser_en   = en;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qm.delete();
        ql.delete();
        lastq.delete();
        held = 0;
    endtask

    task automatic clear_obs();
        obs_m    = '0;
        obs_l    = '0;
        hist     = '0;
        nbits    = 0;
        det_hits = 0;
        det_at   = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid_m"}, 32'(if_m.ser_valid), 32'd0);
        chk({tag, "_bit_m"},   32'(if_m.ser_bit),   32'd0);
        chk({tag, "_done_m"},  32'(if_m.word_done), 32'd0);
        chk({tag, "_busy_m"},  32'(if_m.busy),      32'd0);
        chk({tag, "_rdy_m"},   32'(if_m.in_ready),  32'd0);
        chk({tag, "_valid_l"}, 32'(if_l.ser_valid), 32'd0);
        chk({tag, "_busy_l"},  32'(if_l.busy),      32'd0);
        chk({tag, "_rdy_l"},   32'(if_l.in_ready),  32'd0);
    endtask

    // One clock: apply inputs, check at the falling edge, update the model at the rising edge.
    task automatic step(input logic [7:0] w, input logic v, input logic e);
        logic xfer;
        logic cons;
        logic last;
        word  = w;
        valid = v;
        en    = e;
        @(negedge clk);
        chk("ser_valid_m", 32'(if_m.ser_valid), 32'(held > 0));
        chk("ser_valid_l", 32'(if_l.ser_valid), 32'(held > 0));
        chk("ser_bit_m",   32'(if_m.ser_bit),   32'((held > 0) ? qm[0] : 1'b0));
        chk("ser_bit_l",   32'(if_l.ser_bit),   32'((held > 0) ? ql[0] : 1'b0));
        chk("word_done_m", 32'(if_m.word_done), 32'((held > 0) && e && lastq[0]));
        chk("word_done_l", 32'(if_l.word_done), 32'((held > 0) && e && lastq[0]));
        chk("in_ready",    32'(if_m.in_ready),  32'(held < 2));
        chk("busy",        32'(if_m.busy),      32'(held > 0));
        if (if_m.ser_valid && e) begin
            obs_m = {obs_m[14:0], if_m.ser_bit};
            obs_l = {obs_l[6:0], if_l.ser_bit};
            hist  = {hist[2:0], if_m.ser_bit};
            nbits++;
            if (nbits >= 4 && hist == 4'b1011) begin
                det_hits++;
                if (det_hits == 1) det_at = nbits;
            end
        end
        xfer = v && (held < 2);
        cons = (held > 0) && e;
        @(posedge clk);
        if (cons) begin
            last = lastq.pop_front();
            void'(qm.pop_front());
            void'(ql.pop_front());
            if (last) held--;
        end
        if (xfer) begin
            for (int i = 0; i < 8; i++) begin
                qm.push_back(w[7-i]);
                ql.push_back(w[i]);
                lastq.push_back(i == 7);
            end
            held++;
        end
        #1;
    endtask

    initial begin
        // Async reset before any clock edge
        #2 reset = 1'b1;
        #2 chk_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        clear_obs();

        // Single word B0, MSB first, plus detector check on the stream
        step(8'hB0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(8'h00, 1'b0, 1'b1);
        chk("b0_stream", 32'(obs_m[7:0]), 32'hB0);
        chk("det_hits", 32'(det_hits), 32'd1);
        chk("det_at", 32'(det_at), 32'd4);

        // Back-to-back B5, 0B
        clear_obs();
        step(8'hB5, 1'b1, 1'b1);
        step(8'h0B, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) step(8'h00, 1'b0, 1'b1);
        chk("b2b_stream", 32'(obs_m), 32'hB50B);

        // ser_en stall for 3 cycles after bit 2
        clear_obs();
        step(8'hB5, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        chk("stall_stream", 32'(obs_m[7:0]), 32'hB5);

        // LSB-first instance: 0D goes out as 1,0,1,1,0,0,0,0
        clear_obs();
        step(8'h0D, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(8'h00, 1'b0, 1'b1);
        chk("lsb_stream", 32'(obs_l), 32'hB0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20; i++) step(8'h00, 1'b0, 1'b1);

        // Reset mid-word with the buffer full, then a clean word
        step(8'hFF, 1'b1, 1'b1);
        step(8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
        chk("pre_rst_busy", 32'(if_m.busy), 32'd1);
        #2 reset = 1'b1;
        #1 chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        clear_obs();
        step(8'hB0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(8'h00, 1'b0, 1'b1);
        chk("post_rst_stream", 32'(obs_m), 32'h00B0);
        chk("post_rst_det", 32'(det_hits), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
